clk_count_hr_cfg: RTL and testbench

//  Hour counter for the digital clock. Supersedes the fixed 24-hour counter.

---
 rtl/clk_pkg.sv | 21 ++
 rtl/hr_bin2bcd.sv | 22 ++
 rtl/clk_count_hr_cfg.sv | 117 +++++++++++
 tb/tb_clk_count_hr_cfg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared constants, hour type and 24h->12h mapping for the clock hour counter.
package clk_pkg;

    localparam int HR_MAX_DEF = 23;
    localparam int NOON       = 12;
    localparam int HR_W       = 5;

    typedef logic [HR_W-1:0] hr_t;

    // 0 -> 12, 1..12 unchanged, 13..23 -> hr-12
    function automatic hr_t hr24_to_12(hr_t h);
        if (h == '0) begin
            return hr_t'(NOON);
        end
        if (h > hr_t'(NOON)) begin
            return h - hr_t'(NOON);
        end
        return h;
    endfunction

endpackage

// File: rtl/hr_bin2bcd.sv
// Combinational 5-bit binary to two-digit BCD converter for the hour display.
module hr_bin2bcd
    import clk_pkg::*;
(
    input  hr_t        bin,
    output logic [7:0] bcd
);

    always_comb begin
        bcd = 8'h00;
        if (bin >= 5'd30) begin
            bcd = {4'd3, 4'(bin - 5'd30)};
        end else if (bin >= 5'd20) begin
            bcd = {4'd2, 4'(bin - 5'd20)};
        end else if (bin >= 5'd10) begin
            bcd = {4'd1, 4'(bin - 5'd10)};
        end else begin
            bcd = {4'd0, 4'(bin)};
        end
    end

endmodule

// File: rtl/clk_count_hr_cfg.sv
// Run-time 12h/24h hour counter with load, up/down count and day-rollover ticks.
// Define CLK_HR_BCD_EN for BCD hr_out/load_val instead of plain binary.
module clk_count_hr_cfg
    import clk_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HR_MAX = HR_MAX_DEF
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             rst_counters,
    input  logic             mode_12,
    input  logic             count_up_hr,
    input  logic             count_dn_hr,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] hr_out,
    output logic             pm,
    output logic             day_up_tick,
    output logic             day_dn_tick,
    output logic             load_err
);

    hr_t  hr_q, hr_d;
    logic up_q, up_d;
    logic dn_q, dn_d;
    logic err_q, err_d;

    hr_t  load_hr;
    logic load_ok;
    hr_t  disp;

`ifdef CLK_HR_BCD_EN
    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] load_bin;
    logic [7:0] disp_bcd;

    assign tens     = load_val[7:4];
    assign units    = load_val[3:0];
    assign load_bin = {4'd0, tens} * 8'd10 + {4'd0, units};

    // Anything above the two digits must be zero to count as a legal hour
    assign load_ok  = (tens <= 4'd9) && (units <= 4'd9)
                   && ((load_val >> 8) == '0)
                   && (load_bin <= 8'(HR_MAX));
    assign load_hr  = load_bin[HR_W-1:0];

    hr_bin2bcd u_bcd (
        .bin (disp),
        .bcd (disp_bcd)
    );

    always_comb begin
        hr_out      = '0;
        hr_out[7:0] = disp_bcd;
    end
`else
    assign load_ok = (load_val <= WIDTH'(HR_MAX));
    assign load_hr = load_val[HR_W-1:0];
    assign hr_out  = WIDTH'(disp);
`endif

    assign disp = mode_12 ? hr24_to_12(hr_q) : hr_q;
    assign pm   = (hr_q >= hr_t'(NOON));

    always_comb begin
        hr_d  = hr_q;
        up_d  = 1'b0;
        dn_d  = 1'b0;
        err_d = 1'b0;
        if (rst || rst_counters) begin
            hr_d = '0;
        end else if (load_en) begin
            if (load_ok) begin
                hr_d = load_hr;
            end else begin
                err_d = 1'b1;
            end
        end else if (count_up_hr && count_dn_hr) begin
            hr_d = hr_q;
        end else if (count_up_hr) begin
            if (hr_q == hr_t'(HR_MAX)) begin
                hr_d = '0;
                up_d = 1'b1;
            end else begin
                hr_d = hr_q + 1'b1;
            end
        end else if (count_dn_hr) begin
            if (hr_q == '0) begin
                hr_d = hr_t'(HR_MAX);
                dn_d = 1'b1;
            end else begin
                hr_d = hr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            hr_q  <= '0;
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            hr_q  <= hr_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
            err_q <= err_d;
        end
    end

    assign day_up_tick = up_q;
    assign day_dn_tick = dn_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_clk_count_hr_cfg.sv
// Directed scoreboard bench for the configurable hour counter.
module tb_clk_count_hr_cfg;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         rst, rst_counters, mode_12;
    logic         count_up_hr, count_dn_hr, load_en;
    logic [W-1:0] load_val;
    logic [W-1:0] hr_out;
    logic         pm, day_up_tick, day_dn_tick, load_err;

    typedef struct {
        string        tag;
        logic [W-1:0] hr;
        logic         pm;
        logic         up;
        logic         dn;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    clk_count_hr_cfg #(.WIDTH(W), .HR_MAX(23)) dut (
        .CLK          (CLK),
        .rst          (rst),
        .rst_counters (rst_counters),
        .mode_12      (mode_12),
        .count_up_hr  (count_up_hr),
        .count_dn_hr  (count_dn_hr),
        .load_en      (load_en),
        .load_val     (load_val),
        .hr_out       (hr_out),
        .pm           (pm),
        .day_up_tick  (day_up_tick),
        .day_dn_tick  (day_dn_tick),
        .load_err     (load_err)
    );

    function automatic logic [W-1:0] digits(int d);
`ifdef CLK_HR_BCD_EN
        return W'((d / 10) * 16 + (d % 10));
`else
        return W'(d);
`endif
    endfunction

    function automatic logic [W-1:0] disp(int h, logic m12);
        int d;
        d = h;
        if (m12) begin
            if (h == 0) d = 12;
            else if (h > 12) d = h - 12;
        end
        return digits(d);
    endfunction

    task automatic push(string tag, int eh, logic eu, logic ed, logic ee);
        exp_t e;
        e.tag = tag;
        e.hr  = disp(eh, mode_12);
        e.pm  = (eh >= 12);
        e.up  = eu;
        e.dn  = ed;
        e.err = ee;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty got 0 entries required 1");
            return;
        end
        e = sb.pop_front();
        n_assert++;
        assert (hr_out === e.hr) else begin
            n_fail++;
            $error("FAIL %s hr_out got %0h required %0h", e.tag, hr_out, e.hr);
        end
        n_assert++;
        assert (pm === e.pm) else begin
            n_fail++;
            $error("FAIL %s pm got %b required %b", e.tag, pm, e.pm);
        end
        n_assert++;
        assert (day_up_tick === e.up) else begin
            n_fail++;
            $error("FAIL %s day_up_tick got %b required %b", e.tag, day_up_tick, e.up);
        end
        n_assert++;
        assert (day_dn_tick === e.dn) else begin
            n_fail++;
            $error("FAIL %s day_dn_tick got %b required %b", e.tag, day_dn_tick, e.dn);
        end
        n_assert++;
        assert (load_err === e.err) else begin
            n_fail++;
            $error("FAIL %s load_err got %b required %b", e.tag, load_err, e.err);
        end
    endtask

    // Drive one cycle of inputs, then check the registered result after the edge
    task automatic step(string tag, logic r, logic rc, logic ld, logic [W-1:0] lv,
                        logic up, logic dn, int eh, logic eu, logic ed, logic ee);
        rst          = r;
        rst_counters = rc;
        load_en      = ld;
        load_val     = lv;
        count_up_hr  = up;
        count_dn_hr  = dn;
        @(posedge CLK);
        #1;
        push(tag, eh, eu, ed, ee);
        chk();
    endtask

    task automatic load(string tag, int v, int eh, logic ee);
        step(tag, 1'b0, 1'b0, 1'b1, digits(v), 1'b0, 1'b0, eh, 1'b0, 1'b0, ee);
    endtask

    task automatic idle(string tag, int eh);
        step(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, eh, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mode_chk(string tag, logic m, int eh);
        mode_12 = m;
        #1;
        push(tag, eh, 1'b0, 1'b0, 1'b0);
        chk();
    endtask

    initial begin
        rst          = 1'b1;
        rst_counters = 1'b0;
        mode_12      = 1'b0;
        count_up_hr  = 1'b0;
        count_dn_hr  = 1'b0;
        load_en      = 1'b0;
        load_val     = '0;

        // reset
        step("rst_a", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step("rst_b", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        mode_chk("rst_12h", 1'b1, 0);
        mode_chk("rst_24h", 1'b0, 0);

        // full up walk with wrap tick
        for (int i = 1; i <= 24; i++) begin
            step("up_walk", 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0,
                 i % 24, (i == 24), 1'b0, 1'b0);
        end
        idle("up_tick_clr", 0);

        // down wrap, then up&dn hold
        step("dn_wrap", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 23, 1'b0, 1'b1, 1'b0);
        idle("dn_tick_clr", 23);
        step("dn_plain", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 22, 1'b0, 1'b0, 1'b0);
        load("load5", 5, 5, 1'b0);
        step("up_dn_hold", 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0);

        // 12h display and load range check
        mode_12 = 1'b1;
        load("load17_12h", 17, 17, 1'b0);
        load("load24_err", 24, 17, 1'b1);
        idle("err_clr", 17);
        mode_chk("mode_tog_24", 1'b0, 17);
        mode_chk("mode_tog_12", 1'b1, 17);
        load("load12_12h", 12, 12, 1'b0);
        load("load0_12h", 0, 0, 1'b0);
        load("load13_12h", 13, 13, 1'b0);
        mode_12 = 1'b0;

        // load and resets override counting at wrap
        load("load23", 23, 23, 1'b0);
        step("load_ovr_up", 1'b0, 1'b0, 1'b1, digits(9), 1'b1, 1'b0, 9, 1'b0, 1'b0, 1'b0);
        load("load23_b", 23, 23, 1'b0);
        step("rc_ovr_up", 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step("rc_ovr_dn", 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        step("rst_ovr_err", 1'b1, 1'b0, 1'b1, digits(30), 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step("rc_ovr_err", 1'b0, 1'b1, 1'b1, digits(30), 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // 19 and malformed load values (1A is a bad BCD nibble and 26 binary)
        load("load19", 19, 19, 1'b0);
        step("load_1a_err", 1'b0, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0, 19, 1'b0, 1'b0, 1'b1);
        step("load_97_err", 1'b0, 1'b0, 1'b1, 8'h97, 1'b0, 1'b0, 19, 1'b0, 1'b0, 1'b1);
        idle("final", 19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
